// File: rtl/pio_bank.sv
// Avalon-MM PIO register bank: NUM_OUT output channels with atomic set/clear and
// NUM_IN synchronised inputs. Edge capture, mask and irq exist only with PIO_BANK_IRQ_EN defined.
module pio_bank #(
  parameter int          NUM_OUT   = 4,
  parameter int          NUM_IN    = 2,
  parameter int          DATA_W    = 32,
  parameter int          IN_W      = 2,
  parameter int          EDGE      = 0,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic [5:0]                 avs_address,
  input  logic                       avs_read,
  input  logic                       avs_write,
  input  logic [3:0]                 avs_byteenable,
  input  logic [31:0]                avs_writedata,
  output logic [31:0]                avs_readdata,
  output logic                       irq,
  output logic [NUM_OUT*DATA_W-1:0]  out_export,
  input  logic [NUM_IN*IN_W-1:0]     in_export
);

  localparam logic [DATA_W-1:0] OUT_RST = RESET_VAL[DATA_W-1:0];

  logic [2:0]  grp;
  logic [2:0]  chan;
  logic [31:0] be_mask;
  logic [31:0] wbits;
  logic [31:0] out_rd [8];
  logic [31:0] in_rd  [8];
  logic [31:0] rd_data;
  logic [31:0] rdata_reg;

  // Address splits into an 8-word register group and a channel index.
  assign grp  = avs_address[5:3];
  assign chan = avs_address[2:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      assign be_mask[gi*8 +: 8] = {8{avs_byteenable[gi]}};
    end
  endgenerate

  assign wbits = avs_writedata & be_mask;

  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic [DATA_W-1:0] out_reg;
      logic [DATA_W-1:0] out_next;

      always_comb begin
        out_next = out_reg;
        if (avs_write && chan == 3'(gi)) begin
          case (grp)
            3'd0: out_next = (out_reg & ~be_mask[DATA_W-1:0]) | wbits[DATA_W-1:0];
            3'd1: out_next = out_reg | wbits[DATA_W-1:0];
            3'd2: out_next = out_reg & ~wbits[DATA_W-1:0];
            default: out_next = out_reg;
          endcase
        end
      end

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) out_reg <= OUT_RST;
        else             out_reg <= out_next;
      end

      assign out_export[gi*DATA_W +: DATA_W] = out_reg;
      assign out_rd[gi] = 32'(out_reg);
    end
    for (gi = NUM_OUT; gi < 8; gi++) begin : g_out_none
      assign out_rd[gi] = '0;
    end
  endgenerate

`ifdef PIO_BANK_IRQ_EN
  logic [31:0]       cap_rd [8];
  logic [NUM_IN-1:0] mask_reg;
  logic [NUM_IN-1:0] mask_next;
  logic [NUM_IN-1:0] status_bits;
  logic              irq_reg;

  always_comb begin
    mask_next = mask_reg;
    if (avs_write && grp == 3'd5 && chan == 3'd0)
      mask_next = (mask_reg & ~be_mask[NUM_IN-1:0]) | wbits[NUM_IN-1:0];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      mask_reg <= mask_next;
      irq_reg  <= |status_bits;
    end
  end

  assign irq = irq_reg;
`else
  assign irq = 1'b0;
`endif

  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [IN_W-1:0] s1_reg;
      logic [IN_W-1:0] s2_reg;

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          s1_reg <= '0;
          s2_reg <= '0;
        end else begin
          s1_reg <= in_export[gi*IN_W +: IN_W];
          s2_reg <= s1_reg;
        end
      end

      assign in_rd[gi] = 32'(s2_reg);

`ifdef PIO_BANK_IRQ_EN
      logic [IN_W-1:0] prev_reg;
      logic [IN_W-1:0] edge_det;
      logic [IN_W-1:0] cap_reg;
      logic [IN_W-1:0] cap_next;

      assign edge_det = (EDGE == 0) ? (s2_reg & ~prev_reg) :
                        (EDGE == 1) ? (~s2_reg & prev_reg) :
                                      (s2_reg ^ prev_reg);

      // A fresh edge wins over a simultaneous W1C of the same bit.
      always_comb begin
        cap_next = cap_reg;
        if (avs_write && grp == 3'd4 && chan == 3'(gi))
          cap_next = cap_reg & ~wbits[IN_W-1:0];
        cap_next = cap_next | edge_det;
      end

      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          prev_reg <= '0;
          cap_reg  <= '0;
        end else begin
          prev_reg <= s2_reg;
          cap_reg  <= cap_next;
        end
      end

      assign cap_rd[gi]      = 32'(cap_reg);
      assign status_bits[gi] = (|cap_reg) & mask_reg[gi];
`endif
    end
    for (gi = NUM_IN; gi < 8; gi++) begin : g_in_none
      assign in_rd[gi] = '0;
`ifdef PIO_BANK_IRQ_EN
      assign cap_rd[gi] = '0;
`endif
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    case (grp)
      3'd0: rd_data = out_rd[chan];
      3'd3: rd_data = in_rd[chan];
`ifdef PIO_BANK_IRQ_EN
      3'd4: rd_data = cap_rd[chan];
      3'd5: begin
        if (chan == 3'd0)      rd_data = 32'(mask_reg);
        else if (chan == 3'd1) rd_data = 32'(status_bits);
      end
`endif
      default: rd_data = '0;
    endcase
  end

  // Read data is held between reads; a read colliding with a write returns 0.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)   rdata_reg <= '0;
    else if (avs_read) rdata_reg <= avs_write ? 32'h0 : rd_data;
  end

  assign avs_readdata = rdata_reg;

endmodule

// File: tb/tb_pio_bank.sv
// Randomised scoreboard bench for pio_bank; the reference model follows the register
// map rules directly and adapts to whether PIO_BANK_IRQ_EN is defined.
module tb_pio_bank;
  localparam int          NO  = 4;
  localparam int          NI  = 2;
  localparam int          DW  = 32;
  localparam int          IW  = 2;
  localparam int          EDG = 0;
  localparam logic [31:0] RV  = 32'h5A;

  logic              clk_clk = 1'b0;
  logic              reset_reset = 1'b0;
  logic [5:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [3:0]        avs_byteenable = '0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic [NO*DW-1:0]  out_export;
  logic [NI*IW-1:0]  in_export = '0;

  pio_bank #(.NUM_OUT(NO), .NUM_IN(NI), .DATA_W(DW), .IN_W(IW), .EDGE(EDG), .RESET_VAL(RV)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_byteenable(avs_byteenable),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq),
    .out_export(out_export), .in_export(in_export)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [31:0]     m_out [NO];
  logic [IW-1:0]   m_cap [NI];
  logic [NI-1:0]   m_mask;
  logic            m_irq;
  logic [NI*IW-1:0] pin_q [$];   // [0]=pins at last edge, [1]=synchronised value, [2]=previous
  logic [31:0]     exp_q [$];

  function automatic logic [31:0] model_read(input logic [5:0] a);
    int g = int'(a[5:3]);
    int c = int'(a[2:0]);
    logic [NI*IW-1:0] s2 = pin_q[1];
    if (g == 0 && c < NO) return m_out[c];
    if (g == 3 && c < NI) return 32'(s2[c*IW +: IW]);
`ifdef PIO_BANK_IRQ_EN
    if (g == 4 && c < NI) return 32'(m_cap[c]);
    if (a == 6'h28) return 32'(m_mask);
    if (a == 6'h29) begin
      logic [31:0] st = '0;
      for (int k = 0; k < NI; k++) st[k] = (m_cap[k] != 0) && m_mask[k];
      return st;
    end
`endif
    return 32'h0;
  endfunction

  always @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int k = 0; k < NO; k++) m_out[k] = RV;
      for (int k = 0; k < NI; k++) m_cap[k] = '0;
      m_mask = '0;
      m_irq  = 1'b0;
      pin_q  = '{'0, '0, '0};
      exp_q.delete();
    end else begin
      logic [31:0]   bm, wd;
      logic          irq_new;
      logic [IW-1:0] edges [NI];
      int g, c;
      bm = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
      wd = avs_writedata & bm;
      g  = int'(avs_address[5:3]);
      c  = int'(avs_address[2:0]);
      if (avs_read) exp_q.push_back(avs_write ? 32'h0 : model_read(avs_address));
      irq_new = 1'b0;
      for (int k = 0; k < NI; k++) begin
        logic [IW-1:0] s, p;
        s = pin_q[1][k*IW +: IW];
        p = pin_q[2][k*IW +: IW];
        case (EDG)
          0:       edges[k] = s & ~p;
          1:       edges[k] = ~s & p;
          default: edges[k] = s ^ p;
        endcase
`ifdef PIO_BANK_IRQ_EN
        if (m_cap[k] != 0 && m_mask[k]) irq_new = 1'b1;
`endif
      end
      if (avs_write) begin
        if (g == 0 && c < NO) m_out[c] = (m_out[c] & ~bm) | wd;
        if (g == 1 && c < NO) m_out[c] = m_out[c] | wd;
        if (g == 2 && c < NO) m_out[c] = m_out[c] & ~wd;
`ifdef PIO_BANK_IRQ_EN
        if (g == 4 && c < NI) m_cap[c] = m_cap[c] & ~wd[IW-1:0];
        if (avs_address == 6'h28) m_mask = (m_mask & ~bm[NI-1:0]) | wd[NI-1:0];
`endif
      end
`ifdef PIO_BANK_IRQ_EN
      for (int k = 0; k < NI; k++) m_cap[k] = m_cap[k] | edges[k];
`endif
      m_irq = irq_new;
      pin_q.push_front(in_export);
      void'(pin_q.pop_back());
    end
  end

  // Output/irq monitor on the falling edge
  always @(negedge clk_clk) begin
    if (mon_en) begin
      logic [127:0] e;
      e = '0;
      for (int k = 0; k < NO; k++) e[k*DW +: DW] = m_out[k];
      check("out_export", 128'(out_export), e);
      check("irq", 128'(irq), 128'(m_irq));
    end
  end

  // Read-data monitor: readdata is compared one edge after the read was sampled
  initial begin
    bit rd_pend = 1'b0;
    bit rd_now;
    forever begin
      @(posedge clk_clk);
      rd_now = avs_read && !reset_reset;
      if (reset_reset) rd_pend = 1'b0;
      if (rd_pend) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL readdata: got %h with no expected response queued", avs_readdata);
        end else begin
          check("readdata", 128'(avs_readdata), 128'(exp_q.pop_front()));
        end
      end
      rd_pend = rd_now;
    end
  end

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    $display("WR  addr=%h data=%h be=%b", a, d, be);
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a);
    @(negedge clk_clk);
    avs_address = a; avs_read = 1'b1;
    $display("RD  addr=%h", a);
    @(negedge clk_clk);
    avs_read = 1'b0;
  endtask

  task automatic bus_rw(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    avs_address = a; avs_writedata = d; avs_byteenable = 4'hF;
    avs_read = 1'b1; avs_write = 1'b1;
    $display("RW  addr=%h data=%h", a, d);
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_reset = 1'b1;
    @(negedge clk_clk); @(negedge clk_clk);
    reset_reset = 1'b0;
    mon_en = 1'b1;
    check("reset_out", 128'(out_export), {4{32'h5A}});
    check("reset_irq", 128'(irq), 128'h0);
    check("reset_rdata", 128'(avs_readdata), 128'h0);
    bus_read(6'h00);

    bus_write(6'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(6'h00, 32'h1234_5678, 4'b0101);
    check("byte_en_write", 128'(out_export[31:0]), 128'hFF34FF78);
    bus_write(6'h08, 32'h0000_FF00, 4'hF);
    check("set", 128'(out_export[31:0]), 128'hFF34FF78);
    bus_write(6'h10, 32'hFF00_0000, 4'hF);
    check("clear", 128'(out_export[31:0]), 128'h0034FF78);
    bus_read(6'h00);

    bus_write(6'h28, 32'h1, 4'hF);
    @(negedge clk_clk); in_export = 4'b0001;
    wait_cycles(3); #1;
    check("irq_before_edge4", 128'(irq), 128'h0);
    @(posedge clk_clk); #1;
`ifdef PIO_BANK_IRQ_EN
    check("irq_at_edge4", 128'(irq), 128'h1);
`else
    check("irq_tied_low", 128'(irq), 128'h0);
`endif
    bus_read(6'h20);
    bus_read(6'h18);
    bus_read(6'h29);
    bus_write(6'h20, 32'h1, 4'hF);
`ifdef PIO_BANK_IRQ_EN
    check("irq_hold_after_w1c", 128'(irq), 128'h1);
`endif
    @(posedge clk_clk); #1;
    check("irq_drop_after_w1c", 128'(irq), 128'h0);

    // Re-arm capture, then collide a W1C with a new rising edge on bit 0
    @(negedge clk_clk); in_export = 4'b0000;
    wait_cycles(4);
    @(negedge clk_clk); in_export = 4'b0001;
    wait_cycles(5);
    @(negedge clk_clk); in_export = 4'b0000;
    wait_cycles(4);
    @(negedge clk_clk); in_export = 4'b0001;
    wait_cycles(2);
    bus_write(6'h20, 32'h1, 4'hF);
    wait_cycles(2); #1;
`ifdef PIO_BANK_IRQ_EN
    check("edge_beats_w1c", 128'(irq), 128'h1);
`endif
    bus_read(6'h20);
    bus_write(6'h28, 32'h0, 4'hF);
    @(posedge clk_clk); #1;
    check("irq_drop_after_unmask", 128'(irq), 128'h0);

    bus_read(6'h07);
    bus_read(6'h3F);
    bus_read(6'h1A);
    bus_read(6'h2A);
    bus_write(6'h05, 32'hDEAD_BEEF, 4'hF);
    bus_rw(6'h01, 32'hCAFE_0001);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] a;
      case ($urandom_range(0, 9))
        8:       a = 6'h28 + 6'($urandom_range(0, 1));
        9:       a = 6'($urandom_range(6'h2A, 6'h3F));
        default: a = 6'($urandom_range(0, 6'h27));
      endcase
      case ($urandom_range(0, 5))
        0, 1: bus_write(a, $urandom, 4'($urandom));
        2, 3: bus_read(a);
        4: begin
          @(negedge clk_clk); in_export = 4'($urandom);
          $display("PIN in_export=%b", in_export);
          wait_cycles($urandom_range(0, 3));
        end
        default: bus_rw(a, $urandom);
      endcase
    end

    // Reset asserted during a write
    @(negedge clk_clk);
    avs_address = 6'h00; avs_writedata = 32'h0; avs_byteenable = 4'hF; avs_write = 1'b1;
    #2 reset_reset = 1'b1;
    #1;
    $display("RST mid-write");
    check("midreset_out", 128'(out_export), {4{32'h5A}});
    check("midreset_irq", 128'(irq), 128'h0);
    @(negedge clk_clk);
    avs_write = 1'b0; reset_reset = 1'b0;
    bus_read(6'h00);
    bus_read(6'h20);
    wait_cycles(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rd_queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
